// File: rtl/alu_operand_stage.sv
// alu_operand_stage: builds both ALU operands in ID (shift amount / forwarded rs,
// extended immediate / forwarded rt), resolves MEM/WB forwarding and registers
// the result into the ID/EX boundary with hold, flush and bubble handling.
// Optional load-use stall detection is enabled by defining ALU_OPND_LOADUSE_EN;
// without it id_stall is tied to 0.
module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5,
    parameter int IMM_W = 16,
    parameter int RN_W  = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_qa,
    input  logic [WIDTH-1:0] id_qb,
    input  logic [RN_W-1:0]  id_rs,
    input  logic [RN_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [SA_W-1:0]  id_sa,
    input  logic [IMM_W-1:0] id_imm,
    input  logic             id_shift,
    input  logic             id_aluimm,
    input  logic             id_sext,
    input  logic [RN_W-1:0]  id_rn,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             mem_wreg,
    input  logic [RN_W-1:0]  mem_rn,
    input  logic [WIDTH-1:0] mem_res,
    input  logic             wb_wreg,
    input  logic [RN_W-1:0]  wb_rn,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ex_hold,
    input  logic             flush,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [RN_W-1:0]  ex_rn,
    output logic             ex_wreg,
    output logic             ex_m2reg,
    output logic             id_stall
);

    // Immediate extension; the signed cast handles WIDTH == IMM_W cleanly.
    function automatic logic [WIDTH-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                 input logic sext);
        logic signed [IMM_W-1:0] simm;
        simm = imm;
        return sext ? WIDTH'(simm) : WIDTH'(imm);
    endfunction

    // Forwarding select: MEM beats WB, register 0 never forwards.
    function automatic logic [WIDTH-1:0] fwd(input logic [RN_W-1:0]  rn,
                                             input logic [WIDTH-1:0] rf);
        if (mem_wreg && (mem_rn == rn) && (rn != '0))
            return mem_res;
        else if (wb_wreg && (wb_rn == rn) && (rn != '0))
            return wb_data;
        else
            return rf;
    endfunction

    logic [WIDTH-1:0] fwd_rs, fwd_rt;
    logic [WIDTH-1:0] opa_d, opb_d;

    logic             ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d;
    logic [WIDTH-1:0] ex_b_q, ex_b_d;
    logic [RN_W-1:0]  ex_rn_q, ex_rn_d;
    logic             ex_wreg_q, ex_wreg_d;
    logic             ex_m2reg_q, ex_m2reg_d;

    // Operand construction from forwarded register values, shift amount and immediate.
    always_comb begin
        fwd_rs = fwd(id_rs, id_qa);
        fwd_rt = fwd(id_rt, id_qb);
        opa_d  = id_shift  ? WIDTH'(id_sa) : fwd_rs;
        opb_d  = id_aluimm ? ext_imm(id_imm, id_sext) : fwd_rt;
    end

`ifdef ALU_OPND_LOADUSE_EN
    // A load sitting in EX whose destination is read by ID cannot forward yet.
    assign id_stall = ex_valid_q & ex_m2reg_q & (ex_rn_q != '0) & id_valid &
                      ((id_use_rs & (id_rs == ex_rn_q)) |
                       (id_use_rt & (id_rt == ex_rn_q)));
`else
    // Load-use hazards are scheduled away by the compiler in this build.
    assign id_stall = 1'b0;
    logic unused_loaduse;
    assign unused_loaduse = &{1'b0, id_use_rs, id_use_rt};
`endif

    // Next-state for the ID/EX registers: flush, then hold, then stall bubble, then capture.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_rn_d    = ex_rn_q;
        ex_wreg_d  = ex_wreg_q;
        ex_m2reg_d = ex_m2reg_q;
        if (flush || (!ex_hold && id_stall)) begin
            ex_valid_d = 1'b0;
            ex_wreg_d  = 1'b0;
            ex_m2reg_d = 1'b0;
            ex_a_d     = opa_d;
            ex_b_d     = opb_d;
            ex_rn_d    = id_rn;
        end else if (!ex_hold) begin
            ex_valid_d = id_valid;
            ex_wreg_d  = id_wreg & id_valid;
            ex_m2reg_d = id_m2reg & id_valid;
            ex_a_d     = opa_d;
            ex_b_d     = opb_d;
            ex_rn_d    = id_rn;
        end
    end

    // ID/EX boundary registers; asynchronous clear drops any instruction in flight.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_rn_q    <= '0;
            ex_wreg_q  <= 1'b0;
            ex_m2reg_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_rn_q    <= ex_rn_d;
            ex_wreg_q  <= ex_wreg_d;
            ex_m2reg_q <= ex_m2reg_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_rn    = ex_rn_q;
    assign ex_wreg  = ex_wreg_q;
    assign ex_m2reg = ex_m2reg_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed plan items plus a
// randomised phase, all expectations produced by a behavioural model and
// queued in a scoreboard before each clock edge.
module tb_alu_operand_stage;

    localparam int WIDTH = 32;
    localparam int SA_W  = 5;
    localparam int IMM_W = 16;
    localparam int RN_W  = 5;

    logic             clk = 1'b0;
    logic             clrn;
    logic             id_valid;
    logic [WIDTH-1:0] id_qa, id_qb;
    logic [RN_W-1:0]  id_rs, id_rt;
    logic             id_use_rs, id_use_rt;
    logic [SA_W-1:0]  id_sa;
    logic [IMM_W-1:0] id_imm;
    logic             id_shift, id_aluimm, id_sext;
    logic [RN_W-1:0]  id_rn;
    logic             id_wreg, id_m2reg;
    logic             mem_wreg;
    logic [RN_W-1:0]  mem_rn;
    logic [WIDTH-1:0] mem_res;
    logic             wb_wreg;
    logic [RN_W-1:0]  wb_rn;
    logic [WIDTH-1:0] wb_data;
    logic             ex_hold, flush;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_a, ex_b;
    logic [RN_W-1:0]  ex_rn;
    logic             ex_wreg, ex_m2reg;
    logic             id_stall;

    alu_operand_stage #(.WIDTH(WIDTH), .SA_W(SA_W), .IMM_W(IMM_W), .RN_W(RN_W)) dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_qa(id_qa), .id_qb(id_qb),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_sa(id_sa), .id_imm(id_imm), .id_shift(id_shift), .id_aluimm(id_aluimm),
        .id_sext(id_sext), .id_rn(id_rn), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_res(mem_res),
        .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
        .ex_hold(ex_hold), .flush(flush), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RN_W-1:0]  rn;
        logic             wreg;
        logic             m2reg;
        bit               data_known;
    } ex_t;

    ex_t mst;
    ex_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_fwd(input logic [RN_W-1:0] r, input logic [WIDTH-1:0] rf);
        if (r == 0) return rf;
        if (mem_wreg && mem_rn == r) return mem_res;
        if (wb_wreg && wb_rn == r) return wb_data;
        return rf;
    endfunction

    function automatic logic m_stall();
`ifdef ALU_OPND_LOADUSE_EN
        return mst.valid && mst.m2reg && mst.rn != 0 && id_valid &&
               ((id_use_rs && id_rs == mst.rn) || (id_use_rt && id_rt == mst.rn));
`else
        return 1'b0;
`endif
    endfunction

    function automatic ex_t m_next();
        ex_t n;
        logic [WIDTH-1:0] a, b;
        logic [WIDTH-1:0] imm_ext;
        imm_ext = {{(WIDTH-IMM_W){id_sext & id_imm[IMM_W-1]}}, id_imm};
        a = id_shift ? {{(WIDTH-SA_W){1'b0}}, id_sa} : m_fwd(id_rs, id_qa);
        b = id_aluimm ? imm_ext : m_fwd(id_rt, id_qb);
        n = mst;
        if (flush || (!ex_hold && m_stall())) begin
            n.valid = 0; n.wreg = 0; n.m2reg = 0; n.data_known = 0;
            n.a = a; n.b = b; n.rn = id_rn;
        end else if (!ex_hold) begin
            n.valid = id_valid; n.wreg = id_wreg && id_valid; n.m2reg = id_m2reg && id_valid;
            n.a = a; n.b = b; n.rn = id_rn; n.data_known = 1;
        end
        return n;
    endfunction

    task automatic idle();
        id_valid = 0; id_qa = 0; id_qb = 0; id_rs = 0; id_rt = 0;
        id_use_rs = 0; id_use_rt = 0; id_sa = 0; id_imm = 0;
        id_shift = 0; id_aluimm = 0; id_sext = 0; id_rn = 0;
        id_wreg = 0; id_m2reg = 0; mem_wreg = 0; mem_rn = 0; mem_res = 0;
        wb_wreg = 0; wb_rn = 0; wb_data = 0; ex_hold = 0; flush = 0;
    endtask

    task automatic model_clear();
        mst = '{valid: 0, a: 0, b: 0, rn: 0, wreg: 0, m2reg: 0, data_known: 1};
        sb.delete();
    endtask

    // Drive is already applied; check stall, push expectation, clock, pop and compare.
    task automatic step();
        ex_t e;
        #1;
        check_eq("id_stall", {63'd0, id_stall}, {63'd0, m_stall()});
        sb.push_back(m_next());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            mst = e;
            check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
            check_eq("ex_wreg",  {63'd0, ex_wreg},  {63'd0, e.wreg});
            check_eq("ex_m2reg", {63'd0, ex_m2reg}, {63'd0, e.m2reg});
            if (e.data_known) begin
                check_eq("ex_a",  {32'd0, ex_a}, {32'd0, e.a});
                check_eq("ex_b",  {32'd0, ex_b}, {32'd0, e.b});
                check_eq("ex_rn", {59'd0, ex_rn}, {59'd0, e.rn});
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
        check_eq({tag, "_a"},     {32'd0, ex_a}, 64'd0);
        check_eq({tag, "_b"},     {32'd0, ex_b}, 64'd0);
        check_eq({tag, "_rn"},    {59'd0, ex_rn}, 64'd0);
        check_eq({tag, "_wreg"},  {63'd0, ex_wreg}, 64'd0);
        check_eq({tag, "_m2reg"}, {63'd0, ex_m2reg}, 64'd0);
    endtask

    logic [WIDTH-1:0] held_a;

    initial begin
        idle();
        clrn = 0;
        model_clear();
        #12;
        check_all_zero("rst_init");
        clrn = 1;
        @(posedge clk); #1;

        // Load some state, then reset mid-cycle with no edge.
        id_valid = 1; id_qa = 32'h1234; id_qb = 32'h5678; id_rn = 7; id_wreg = 1; id_m2reg = 1;
        step();
        #2 clrn = 0;
        #1 check_all_zero("rst_mid");
        #1 clrn = 1;
        model_clear();
        idle();

        // Plain capture after reset.
        id_valid = 1; id_qa = 5; id_qb = 7;
        step();
        check_eq("cap_a", {32'd0, ex_a}, 64'd5);
        check_eq("cap_b", {32'd0, ex_b}, 64'd7);
        check_eq("cap_valid", {63'd0, ex_valid}, 64'd1);

        // Shift amount and immediate extension.
        idle(); id_valid = 1; id_shift = 1; id_sa = 5'd31;
        id_aluimm = 1; id_imm = 16'h8000; id_sext = 1;
        step();
        check_eq("sa31", {32'd0, ex_a}, 64'h1F);
        check_eq("sext", {32'd0, ex_b}, 64'hFFFF8000);
        id_sext = 0;
        step();
        check_eq("zext", {32'd0, ex_b}, 64'h00008000);

        // Forwarding priority.
        idle(); id_valid = 1; id_rs = 3; id_qa = 32'h11;
        mem_wreg = 1; mem_rn = 3; mem_res = 32'hAA; wb_wreg = 1; wb_rn = 3; wb_data = 32'hBB;
        step();
        check_eq("fwd_mem", {32'd0, ex_a}, 64'hAA);
        mem_wreg = 0;
        step();
        check_eq("fwd_wb", {32'd0, ex_a}, 64'hBB);
        mem_wreg = 1; id_rs = 0; mem_rn = 0; wb_rn = 0;
        step();
        check_eq("fwd_r0", {32'd0, ex_a}, 64'h11);
        id_rt = 3; id_qb = 32'h22; mem_rn = 3; wb_rn = 3;
        step();
        check_eq("fwd_rt_mem", {32'd0, ex_b}, 64'hAA);

        // Hold for three cycles with changing inputs, then flush during hold.
        idle(); id_valid = 1; id_qa = 32'h77; id_rn = 9; id_wreg = 1;
        step();
        held_a = ex_a;
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            id_qa = 32'h100 + i; id_rn = 5'(i); id_valid = i[0];
            step();
            check_eq("hold_a", {32'd0, ex_a}, {32'd0, held_a});
        end
        flush = 1;
        step();
        check_eq("flush_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("flush_wreg", {63'd0, ex_wreg}, 64'd0);
        idle();

        // Load-use: lw r4 into EX, then an instruction reading r4.
        id_valid = 1; id_rn = 4; id_wreg = 1; id_m2reg = 1;
        step();
        idle(); id_valid = 1; id_rs = 4; id_use_rs = 1; id_qa = 32'h44; id_rn = 8; id_wreg = 1;
        #1;
`ifdef ALU_OPND_LOADUSE_EN
        check_eq("lu_stall", {63'd0, id_stall}, 64'd1);
        step();
        check_eq("lu_bubble", {63'd0, ex_valid}, 64'd0);
        // Reload the load into EX and retry with rs=0 and with use_rs=0.
        idle(); id_valid = 1; id_rn = 4; id_wreg = 1; id_m2reg = 1;
        step();
        idle(); id_valid = 1; id_rs = 0; id_use_rs = 1;
        #1 check_eq("lu_rs0", {63'd0, id_stall}, 64'd0);
        id_rs = 4; id_use_rs = 0;
        #1 check_eq("lu_nouse", {63'd0, id_stall}, 64'd0);
        step();
        check_eq("lu_nouse_cap", {63'd0, ex_valid}, 64'd1);
`else
        check_eq("lu_off_stall", {63'd0, id_stall}, 64'd0);
        step();
        check_eq("lu_off_cap", {63'd0, ex_valid}, 64'd1);
        check_eq("lu_off_a", {32'd0, ex_a}, 64'h44);
`endif

        // Randomised phase with small register numbers to provoke forwarding.
        for (int i = 0; i < 80; i++) begin
            id_valid = 1'($urandom); id_qa = $urandom; id_qb = $urandom;
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_sa = 5'($urandom); id_imm = 16'($urandom);
            id_shift = ($urandom_range(0, 3) == 0); id_aluimm = ($urandom_range(0, 2) == 0);
            id_sext = 1'($urandom); id_rn = 5'($urandom_range(0, 3));
            id_wreg = 1'($urandom); id_m2reg = 1'($urandom);
            mem_wreg = 1'($urandom); mem_rn = 5'($urandom_range(0, 3)); mem_res = $urandom;
            wb_wreg = 1'($urandom); wb_rn = 5'($urandom_range(0, 3)); wb_data = $urandom;
            ex_hold = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
